// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// The FIFO takes the slave side; the stage driving it takes the master side.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [DATA_W-1:0] din;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, rd_en,
      input  dout, rd_valid, full, empty,
      input  almost_full, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, rd_valid, full, empty,
      output almost_full, almost_empty, count,
      output overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO, power-of-2 depth, simultaneous read and write.
// SYNC_FIFO_FWFT_EN selects first-word-fall-through output instead of registered read.
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, udf_q;
   logic              full, empty;
   logic              wr_acc, rd_acc;

   // Status flags decode the registered occupancy only.
   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign wr_acc = bus.wr_en && !full;
   assign rd_acc = bus.rd_en && !empty;

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
   assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

   // Next pointer and occupancy from the accepted requests.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (rd_acc) rptr_d = rptr_q + AW'(1);
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array; not reset, and a reset cycle blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem_q[wptr_q] <= bus.din;
   end

   // Pointers, occupancy and the one-cycle reject pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= bus.wr_en && full;
         udf_q   <= bus.rd_en && empty;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word falls through; rd_en acknowledges it.
   assign bus.dout     = empty ? '0 : mem_q[rptr_q];
   assign bus.rd_valid = !empty;
`else
   logic [DATA_W-1:0] dout_q;
   logic              rd_valid_q;

   assign bus.dout     = dout_q;
   assign bus.rd_valid = rd_valid_q;

   // Registered read: dout updates only on an accepted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) dout_q <= mem_q[rptr_q];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue model checked every cycle plus directed literals.
// Build with +define+SYNC_FIFO_FWFT_EN to exercise the fall-through variant.
module tb_sync_fifo_param;
   localparam int DW = 8;
   localparam int DP = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 1'b0;

   sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

   sync_fifo_param #(
      .DATA_W(DW), .DEPTH(DP), .AF_THRESH(DP - 2), .AE_THRESH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: a queue plus the registered side outputs.
   logic [7:0] q[$];
   logic [7:0] m_dout = 8'h00;
   bit         m_rv = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit f, e, wa, ra;
      if (rst) begin
         q.delete();
         m_dout = 8'h00;
         m_rv = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         f  = (q.size() == DP);
         e  = (q.size() == 0);
         wa = bus.wr_en && !f;
         ra = bus.rd_en && !e;
         m_ovf = bus.wr_en && f;
         m_udf = bus.rd_en && e;
         m_rv = ra;
         if (ra) m_dout = q.pop_front();
         if (wa) q.push_back(bus.din);
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = q.size();
         chk("count", 32'(bus.count), 32'(n));
         chk("full", 32'(bus.full), 32'(n == DP));
         chk("empty", 32'(bus.empty), 32'(n == 0));
         chk("almost_full", 32'(bus.almost_full), 32'(n >= DP - 2));
         chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
         chk("overflow", 32'(bus.overflow), 32'(m_ovf));
         chk("underflow", 32'(bus.underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
         chk("dout", 32'(bus.dout), 32'((n != 0) ? q[0] : 8'h00));
         chk("rd_valid", 32'(bus.rd_valid), 32'(n != 0));
`else
         chk("dout", 32'(bus.dout), 32'(m_dout));
         chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
`endif
      end
   end

   task automatic step(input bit r, input bit w, input logic [7:0] d,
                       input bit rd);
      rst = r;
      bus.wr_en = w;
      bus.din = d;
      bus.rd_en = rd;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [7:0] ev;
      bit         hi;
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      chk_en = 1'b1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_ae", 32'(bus.almost_empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_rv", 32'(bus.rd_valid), 32'd0);

      for (int i = 1; i <= 16; i++) begin
         step(0, 1, 8'(i), 0);
         chk("fill_count", 32'(bus.count), 32'(i));
         if (i == 13) chk("af_13", 32'(bus.almost_full), 32'd0);
         if (i == 14) chk("af_14", 32'(bus.almost_full), 32'd1);
      end
      chk("fill_full", 32'(bus.full), 32'd1);

      step(0, 1, 8'hAA, 0);
      chk("ovf_pulse", 32'(bus.overflow), 32'd1);
      chk("ovf_count", 32'(bus.count), 32'd16);
      step(0, 0, 8'h00, 0);
      chk("ovf_clear", 32'(bus.overflow), 32'd0);

      for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         chk("drain_dout", 32'(bus.dout), 32'(i));
         chk("drain_rv", 32'(bus.rd_valid), 32'd1);
         step(0, 0, 8'h00, 1);
`else
         step(0, 0, 8'h00, 1);
         chk("drain_dout", 32'(bus.dout), 32'(i));
         chk("drain_rv", 32'(bus.rd_valid), 32'd1);
`endif
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);
      step(0, 0, 8'h00, 1);
      chk("udf_pulse", 32'(bus.underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("udf_dout", 32'(bus.dout), 32'd0);
`else
      chk("udf_dout", 32'(bus.dout), 32'h10);
      chk("udf_rv", 32'(bus.rd_valid), 32'd0);
`endif

      for (int k = 0; k < 8; k++) step(0, 1, 8'(8'h20 + k), 0);
      for (int k = 0; k < 20; k++) begin
         ev = (k < 8) ? 8'(8'h20 + k) : 8'(8'h30 + k - 8);
`ifdef SYNC_FIFO_FWFT_EN
         chk("wrap_dout", 32'(bus.dout), 32'(ev));
         step(0, 1, 8'(8'h30 + k), 1);
`else
         step(0, 1, 8'(8'h30 + k), 1);
         chk("wrap_dout", 32'(bus.dout), 32'(ev));
`endif
         chk("wrap_count", 32'(bus.count), 32'd8);
      end

      step(1, 0, 8'h00, 0);
      for (int k = 0; k < 5; k++) step(0, 1, 8'(8'h40 + k), 0);
      chk("pre_rst_count", 32'(bus.count), 32'd5);
      step(1, 1, 8'h77, 0);
      chk("rst_wr_count", 32'(bus.count), 32'd0);
      chk("rst_wr_empty", 32'(bus.empty), 32'd1);
      chk("rst_wr_rv", 32'(bus.rd_valid), 32'd0);
      step(0, 0, 8'h00, 0);
      chk("rst_wr_after", 32'(bus.count), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
      step(0, 1, 8'h5A, 0);
      chk("fwft_dout", 32'(bus.dout), 32'h5A);
      chk("fwft_rv", 32'(bus.rd_valid), 32'd1);
      step(0, 0, 8'h00, 1);
      chk("fwft_empty", 32'(bus.empty), 32'd1);
      chk("fwft_dout0", 32'(bus.dout), 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         hi = ((i / 150) % 2) == 1;
         step($urandom_range(0, 199) == 0,
              hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
              8'($urandom),
              hi ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end

      step(0, 0, 8'h00, 0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
